// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle for mem_port_arbiter: CPU and debug/DMA requester ports plus the Memoria port.
// The slave modport is the arbiter's view; master is the requester/memory environment view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              cpu_req;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_done;
   logic [31:0]       cpu_rdata;
   logic              cpu_err;

   logic              dbg_req;
   logic              dbg_wr;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       dbg_wdata;
   logic              dbg_done;
   logic [31:0]       dbg_rdata;
   logic              dbg_err;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [1:0]        arb_state;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output cpu_done, cpu_rdata, cpu_err,
      output dbg_done, dbg_rdata, dbg_err,
      output mem_addr, mem_wr, mem_wdata,
      output arb_state
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  cpu_done, cpu_rdata, cpu_err,
      input  dbg_done, dbg_rdata, dbg_err,
      input  mem_addr, mem_wr, mem_wdata,
      input  arb_state
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing single-port Memoria between the CPU datapath and the debug/DMA port.
// One access in flight: IDLE picks a winner, ACC drives memory for MEM_LAT cycles, RESP pulses done.
module mem_port_arbiter #(
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 32
) (
   input  logic              i_clock,
   input  logic              i_reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

   state_t            r_state;
   logic              r_lastDbg;
   logic              r_winDbg;
   logic              r_wr;
   logic              r_rdEn;
   logic [1:0]        r_cnt;
   logic [ADDR_W-1:0] r_memAddr;
   logic [31:0]       r_memWdata;
   logic              r_memWr;
   logic              r_cpuDone;
   logic              r_dbgDone;
   logic              r_cpuErr;
   logic              r_dbgErr;

   logic              w_anyReq;
   logic              w_pickDbg;
   logic              w_reqWr;
   logic [ADDR_W-1:0] w_reqAddr;
   logic [31:0]       w_reqWdata;

   // On a tie the side that was not granted last time wins.
   assign w_anyReq   = bus.cpu_req | bus.dbg_req;
   assign w_pickDbg  = bus.dbg_req & (~bus.cpu_req | ~r_lastDbg);
   assign w_reqWr    = w_pickDbg ? bus.dbg_wr    : bus.cpu_wr;
   assign w_reqAddr  = w_pickDbg ? bus.dbg_addr  : bus.cpu_addr;
   assign w_reqWdata = w_pickDbg ? bus.dbg_wdata : bus.cpu_wdata;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_lastDbg  <= 1'b1;
         r_winDbg   <= 1'b0;
         r_wr       <= 1'b0;
         r_rdEn     <= 1'b0;
         r_cnt      <= 2'd0;
         r_memAddr  <= '0;
         r_memWdata <= 32'd0;
         r_memWr    <= 1'b0;
         r_cpuDone  <= 1'b0;
         r_dbgDone  <= 1'b0;
         r_cpuErr   <= 1'b0;
         r_dbgErr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_winDbg  <= w_pickDbg;
                  r_lastDbg <= w_pickDbg;
                  r_wr      <= w_reqWr;
                  if (w_reqAddr[1:0] != 2'b00) begin
                     r_state   <= RESP;
                     r_cpuDone <= ~w_pickDbg;
                     r_dbgDone <= w_pickDbg;
                     r_cpuErr  <= ~w_pickDbg;
                     r_dbgErr  <= w_pickDbg;
                     r_rdEn    <= 1'b0;
                  end else begin
                     r_state    <= ACC;
                     r_cnt      <= LAT_LOAD;
                     r_memAddr  <= w_reqAddr;
                     r_memWdata <= w_reqWdata;
                     r_memWr    <= w_reqWr;
                  end
               end
            end
            ACC: begin
               r_memWr <= 1'b0;
               if (r_cnt == 2'd0) begin
                  r_state   <= RESP;
                  r_cpuDone <= ~r_winDbg;
                  r_dbgDone <= r_winDbg;
                  r_rdEn    <= ~r_wr;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            RESP: begin
               r_state    <= IDLE;
               r_cpuDone  <= 1'b0;
               r_dbgDone  <= 1'b0;
               r_cpuErr   <= 1'b0;
               r_dbgErr   <= 1'b0;
               r_rdEn     <= 1'b0;
               r_memAddr  <= '0;
               r_memWdata <= 32'd0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read data arrives from Memoria in the RESP cycle itself, so it is passed through, gated.
   assign bus.cpu_rdata = (r_rdEn && !r_winDbg) ? bus.mem_rdata : 32'd0;
   assign bus.dbg_rdata = (r_rdEn &&  r_winDbg) ? bus.mem_rdata : 32'd0;
   assign bus.cpu_done  = r_cpuDone;
   assign bus.dbg_done  = r_dbgDone;
   assign bus.cpu_err   = r_cpuErr;
   assign bus.dbg_err   = r_dbgErr;
   assign bus.mem_addr  = r_memAddr;
   assign bus.mem_wr    = r_memWr;
   assign bus.mem_wdata = r_memWdata;
   assign bus.arb_state = r_state;
endmodule
